// File: rtl/l2_array_pkg.sv
// Shared types and elaboration helpers for the L2 multi-port array.
package l2_array_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } flush_state_e;

  function automatic int unsigned num_lanes(input int unsigned width,
                                            input int unsigned gran);
    return (gran == 0) ? 1 : width / gran;
  endfunction

  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned gran,
                                   input int unsigned nrd);
    return (gran != 0) && ((width % gran) == 0) && (nrd >= 1);
  endfunction

endpackage

// File: rtl/l2_flush_seq.sv
// Flush sequencer: walks a pointer over every set, one clear per cycle.
module l2_flush_seq
  import l2_array_pkg::*;
#(
  parameter int unsigned S_INDEX = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_req,
  output logic               clr_en,
  output logic [S_INDEX-1:0] clr_idx,
  output logic               flush_busy,
  output logic               flush_done,
  output logic               load_ready
);

  flush_state_e       state;
  logic [S_INDEX-1:0] ptr;

  // State and pointer update; requests outside IDLE are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            state <= SWEEP;
            ptr   <= '0;
          end
        end
        SWEEP: begin
          ptr <= ptr + 1'b1;
          if (ptr == '1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign clr_en     = (state == SWEEP);
  assign clr_idx    = ptr;
  assign flush_busy = (state == SWEEP);
  assign flush_done = (state == DONE);
  assign load_ready = (state != SWEEP);

endmodule

// File: rtl/l2_mport_array.sv
// L2 tag/state array: masked writes, packed combinational read ports,
// optional write-to-read bypass and a one-set-per-cycle flush sweep.
module l2_mport_array
  import l2_array_pkg::*;
#(
  parameter int unsigned S_INDEX   = 3,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned MASK_GRAN = 8,
  parameter int unsigned BYPASS    = 1,
  localparam int unsigned NUM_LANES = num_lanes(WIDTH, MASK_GRAN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [S_INDEX-1:0]        windex,
  input  logic [WIDTH-1:0]          datain,
  input  logic [NUM_LANES-1:0]      wmask,
  output logic                      load_ready,
  input  logic [NUM_RD*S_INDEX-1:0] rindex,
  output logic [NUM_RD*WIDTH-1:0]   dataout,
  input  logic                      flush_req,
  output logic                      flush_busy,
  output logic                      flush_done
);

  localparam int unsigned NUM_SETS   = 2 ** S_INDEX;
  localparam bit          USE_BYPASS = (BYPASS != 0);

  if (!params_ok(WIDTH, MASK_GRAN, NUM_RD)) begin : g_param_err
    $error("l2_mport_array: WIDTH must be a multiple of MASK_GRAN and NUM_RD >= 1");
  end

  logic [WIDTH-1:0]   mem [NUM_SETS];
  logic               clr_en;
  logic [S_INDEX-1:0] clr_idx;
  logic               wr_hit;
  logic [WIDTH-1:0]   wr_merged;

  l2_flush_seq #(
    .S_INDEX (S_INDEX)
  ) u_flush_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_req  (flush_req),
    .clr_en     (clr_en),
    .clr_idx    (clr_idx),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .load_ready (load_ready)
  );

  assign wr_hit = load && load_ready;

  // Word that the addressed set holds after this cycle's masked write.
  always_comb begin
    wr_merged = mem[windex];
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (wmask[k]) wr_merged[k*MASK_GRAN +: MASK_GRAN] = datain[k*MASK_GRAN +: MASK_GRAN];
    end
  end

  // Storage: reset clears all sets; writes and sweep clears never coincide
  // because load_ready is low for the whole sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SETS; i++) mem[i] <= '0;
    end else begin
      if (wr_hit) begin
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
          if (wmask[k]) mem[windex][k*MASK_GRAN +: MASK_GRAN] <= datain[k*MASK_GRAN +: MASK_GRAN];
        end
      end
      if (clr_en) mem[clr_idx] <= '0;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [S_INDEX-1:0] ridx;
    assign ridx = rindex[p*S_INDEX +: S_INDEX];
    assign dataout[p*WIDTH +: WIDTH] =
      (USE_BYPASS && wr_hit && (ridx == windex)) ? wr_merged : mem[ridx];
  end

endmodule

// File: tb/tb_l2_mport_array.sv
// Randomised scoreboard bench for l2_mport_array (bypass and non-bypass builds).
module tb_l2_mport_array;

  localparam int SI = 3;
  localparam int W  = 32;
  localparam int NR = 2;
  localparam int NS = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [SI-1:0] windex;
  logic [W-1:0]  datain;
  logic [3:0]    wmask;
  logic [NR*SI-1:0] rindex;
  logic          flush_req;

  logic          ready_b, busy_b, done_b;
  logic          ready_n, busy_n, done_n;
  logic [NR*W-1:0] dout_b, dout_n;

  always #5 clk = ~clk;

  l2_mport_array #(.S_INDEX(SI), .WIDTH(W), .NUM_RD(NR), .MASK_GRAN(8), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .load(load), .windex(windex), .datain(datain),
    .wmask(wmask), .load_ready(ready_b), .rindex(rindex), .dataout(dout_b),
    .flush_req(flush_req), .flush_busy(busy_b), .flush_done(done_b));

  l2_mport_array #(.S_INDEX(SI), .WIDTH(W), .NUM_RD(NR), .MASK_GRAN(8), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .load(load), .windex(windex), .datain(datain),
    .wmask(wmask), .load_ready(ready_n), .rindex(rindex), .dataout(dout_n),
    .flush_req(flush_req), .flush_busy(busy_n), .flush_done(done_n));

  typedef struct {
    int          kind;   // 0 rd bypass, 1 rd no-bypass, 2..4 ctrl bypass, 5..7 ctrl no-bypass
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   armed    = 0;

  // Reference model: contents plus the edge at which the current sweep began.
  logic [31:0] mdl [NS];
  int          ecount = 0;
  int          ts     = -1000;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (new_w & bm) | (old_w & ~bm);
  endfunction

  function automatic int phase();
    return ecount - ts;  // 0..7 sweeping, 8 done, anything else idle
  endfunction

  task automatic push(input int kind, input int port, input logic [31:0] e, input string nm);
    exp_t x;
    x.kind = kind; x.port = port; x.exp = e; x.name = nm;
    q.push_back(x);
  endtask

  task automatic push_expect();
    int ph;
    bit busy, done, lr;
    ph   = phase();
    busy = (ph >= 0) && (ph < NS);
    done = (ph == NS);
    lr   = !busy;
    for (int p = 0; p < NR; p++) begin
      int idx;
      logic [31:0] base, byp;
      idx  = int'(rindex[p*SI +: SI]);
      base = mdl[idx];
      byp  = (load && lr && (idx == int'(windex))) ? merge(mdl[windex], datain, wmask) : base;
      push(0, p, byp,  "rd_bypass");
      push(1, p, base, "rd_nobypass");
    end
    push(2, 0, {31'd0, busy}, "busy_b");
    push(3, 0, {31'd0, done}, "done_b");
    push(4, 0, {31'd0, lr},   "ready_b");
    push(5, 0, {31'd0, busy}, "busy_nb");
    push(6, 0, {31'd0, done}, "done_nb");
    push(7, 0, {31'd0, lr},   "ready_nb");
  endtask

  task automatic model_edge();
    int ph;
    ph = phase();
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) mdl[i] = '0;
      ts = -1000;
    end else if (ph >= 0 && ph < NS) begin
      mdl[ph] = '0;
    end else begin
      if (load) mdl[windex] = merge(mdl[windex], datain, wmask);
      if (ph != NS && flush_req) ts = ecount + 1;
    end
    ecount++;
  endtask

  task automatic step();
    if (armed) push_expect();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] m);
    load = 1'b1; windex = idx[SI-1:0]; datain = d; wmask = m;
    step();
    load = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < NS; i++) begin
      logic [SI-1:0] a, b;
      a = i[SI-1:0];
      b = 3'(NS - 1 - i);
      rindex = {b, a};
      step();
    end
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t x;
        logic [31:0] act;
        x = q.pop_front();
        case (x.kind)
          0: act = dout_b[x.port*W +: W];
          1: act = dout_n[x.port*W +: W];
          2: act = {31'd0, busy_b};
          3: act = {31'd0, done_b};
          4: act = {31'd0, ready_b};
          5: act = {31'd0, busy_n};
          6: act = {31'd0, done_n};
          default: act = {31'd0, ready_n};
        endcase
        n_checks++;
        if (act === x.exp) n_pass++;
        else $display("FAIL %s port%0d t=%0t got=%h want=%h", x.name, x.port, $time, act, x.exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; windex = '0; datain = '0; wmask = '0;
    rindex = '0; flush_req = 1'b0;
    for (int i = 0; i < NS; i++) mdl[i] = '0;
    step(); step();
    rst_n = 1'b1; armed = 1;
    read_all();

    // Fill with ones then a one-cycle reset.
    for (int i = 0; i < NS; i++) wr(i, 32'hFFFF_FFFF, 4'hF);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    read_all();

    // Masked write and a mask-less write on set 5.
    rindex = {3'd5, 3'd5};
    wr(5, 32'h1122_3344, 4'hF);
    wr(5, 32'hAABB_CCDD, 4'b0101);
    wr(5, 32'h5555_5555, 4'b0000);
    step();

    // Same-index bypass on both ports.
    rindex = {3'd3, 3'd3};
    wr(3, 32'hDEAD_BEEF, 4'hF);
    step();

    // Flush sweep with loads throughout (dropped while busy, taken in DONE).
    for (int i = 0; i < NS; i++) wr(i, $urandom, 4'hF);
    flush_req = 1'b1; step(); flush_req = 1'b0;
    for (int c = 0; c < NS + 2; c++) begin
      rindex = 6'($urandom);
      load = 1'b1; windex = (c == 1) ? 3'd6 : 3'($urandom);
      datain = $urandom; wmask = 4'hF;
      step();
    end
    load = 1'b0;
    read_all();

    // Reset in the middle of a sweep, then a clean full sweep.
    for (int i = 0; i < NS; i++) wr(i, $urandom, 4'($urandom));
    flush_req = 1'b1; step(); flush_req = 1'b0;
    for (int c = 0; c < 3; c++) begin rindex = 6'($urandom); step(); end
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) wr(i, $urandom, 4'hF);
    flush_req = 1'b1; step();
    for (int c = 0; c < 12; c++) begin rindex = 6'($urandom); step(); end
    flush_req = 1'b0;
    read_all();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 99) >= 2);
      load      = $urandom_range(0, 1) == 1;
      windex    = 3'($urandom);
      datain    = $urandom;
      wmask     = 4'($urandom);
      flush_req = ($urandom_range(0, 99) < 5);
      rindex    = ($urandom_range(0, 3) == 0) ? {windex, windex} : 6'($urandom);
      step();
    end
    rst_n = 1'b1; load = 1'b0; flush_req = 1'b0;
    read_all();

    @(negedge clk); #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d pending want=0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
